// File: rtl/logic_op_lab_if.sv
// Board-side bundle for logic_op_lab: keys/switches in, LEDs and sweep status out.
interface logic_op_lab_if #(
    parameter int width = 4,
    parameter int w_cnt = 16
);
    logic [3:0]       key;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             inject_fault;
    logic [width-1:0] result;
    logic [2:0]       mode;
    logic             hold;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [w_cnt-1:0] mismatch_count;

    modport master (
        output key, a, b, inject_fault,
        input  result, mode, hold, busy, pass, fail, mismatch_count
    );
    modport slave (
        input  key, a, b, inject_fault,
        output result, mode, hold, busy, pass, fail, mismatch_count
    );
endinterface

// File: rtl/logic_op_lab.sv
// Bitwise-logic trainer: key-stepped operation select, operand hold, and an
// exhaustive De Morgan / gate-level XOR self-check sweep.
module logic_op_lab #(
    parameter int width           = 4,
    parameter int debounce_cycles = 50000,
    parameter int w_cnt           = 16
) (
    input  logic          clk,
    input  logic          rst,
    logic_op_lab_if.slave bus
);
    localparam int DW = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam int IW = 2 * width;
    localparam int CW = w_cnt + 2;
    localparam logic [w_cnt-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [width-1:0] logic_op(input logic [2:0] m,
                                                  input logic [width-1:0] x,
                                                  input logic [width-1:0] y);
        logic [width-1:0] r;
        case (m)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x & y);
            3'd4:    r = ~(x | y);
            3'd5:    r = ~(x ^ y);
            3'd6:    r = (~x & y) | (x & ~y);
            default: r = (~(x & y)) ^ (~x | ~y);
        endcase
        return r;
    endfunction

    // Assert asynchronously, release through two flops.
    logic [1:0] rst_sync_q;
    logic       rst_n_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_i = rst_sync_q[1];

    // Key path: sync -> debounce -> rising-edge pulse.
    logic [3:0]          key_s1_q, key_s2_q;
    logic [3:0]          deb_q, deb_d, deb_dly_q, press_q;
    logic [3:0][DW-1:0]  dcnt_q, dcnt_d;

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int k = 0; k < 4; k++) begin
            if (key_s2_q[k] != deb_q[k]) begin
                if (dcnt_q[k] == DW'(debounce_cycles - 1)) deb_d[k] = key_s2_q[k];
                else                                       dcnt_d[k] = dcnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_s1_q  <= '0;
            key_s2_q  <= '0;
            deb_q     <= '0;
            dcnt_q    <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
        end else begin
            key_s1_q  <= bus.key;
            key_s2_q  <= key_s1_q;
            deb_q     <= deb_d;
            dcnt_q    <= dcnt_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
        end
    end

    // Operand / mode / result datapath.
    logic [width-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [width-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic [2:0]       mode_q, mode_d;
    logic             hold_q, hold_d;

    always_comb begin
        // Result is formed from the operand-register inputs so a switch change
        // reaches the LEDs after the two sync flops plus the result flop.
        opa_d    = hold_q ? opa_q : a_s2_q;
        opb_d    = hold_q ? opb_q : b_s2_q;
        result_d = logic_op(mode_q, opa_d, opb_d);
        hold_d   = hold_q ^ press_q[2];
        mode_d   = mode_q;
        case (press_q[1:0])
            2'b01:   mode_d = mode_q + 3'd1;
            2'b10:   mode_d = mode_q - 3'd1;
            default: mode_d = mode_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_s1_q   <= '0;
            a_s2_q   <= '0;
            b_s1_q   <= '0;
            b_s2_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            mode_q   <= '0;
            hold_q   <= 1'b0;
        end else begin
            a_s1_q   <= bus.a;
            a_s2_q   <= a_s1_q;
            b_s1_q   <= bus.b;
            b_s2_q   <= b_s1_q;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            mode_q   <= mode_d;
            hold_q   <= hold_d;
        end
    end

    // Sweep engine: one {ta,tb} vector per RUN cycle.
    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [w_cnt-1:0] cnt_q, cnt_d, cnt_next;
    logic             busy_q, busy_d, pass_q, pass_d, fail_q, fail_d;
    logic [width-1:0] ta, tb, l1_rhs;
    logic             l1_bad, l2_bad, x_bad;
    logic [1:0]       n_err;
    logic [CW-1:0]    cnt_sum;

    always_comb begin
        ta       = idx_q[IW-1:width];
        tb       = idx_q[width-1:0];
        l1_rhs   = bus.inject_fault ? (~ta & ~tb) : (~ta | ~tb);
        l1_bad   = (~(ta & tb)) != l1_rhs;
        l2_bad   = (~(ta | tb)) != (~ta & ~tb);
        x_bad    = ((~ta & tb) | (ta & ~tb)) != (ta ^ tb);
        n_err    = {1'b0, l1_bad} + {1'b0, l2_bad} + {1'b0, x_bad};
        cnt_sum  = CW'(cnt_q) + CW'(n_err);
        cnt_next = (cnt_sum[CW-1:w_cnt] != '0) ? CNT_MAX : cnt_sum[w_cnt-1:0];

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (press_q[3]) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_next;
                idx_d = idx_q + 1'b1;
                if (&idx_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    pass_d  = (cnt_next == '0);
                    fail_d  = (cnt_next != '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.result         = result_q;
    assign bus.mode           = mode_q;
    assign bus.hold           = hold_q;
    assign bus.busy           = busy_q;
    assign bus.pass           = pass_q;
    assign bus.fail           = fail_q;
    assign bus.mismatch_count = cnt_q;
endmodule
